// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: MEM/WB forwarding selects, load-use stall,
// taken-branch flushes and a counter-driven multi-cycle EX hold FSM.
module hazard_ctrl #(
  parameter int ADDR_W = 5,
  parameter int NSRC   = 2,
  parameter int MD_LAT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NSRC*ADDR_W-1:0] RsD,
  input  logic [NSRC*ADDR_W-1:0] RsE,
  input  logic [ADDR_W-1:0]      RdE,
  input  logic [ADDR_W-1:0]      RdM,
  input  logic [ADDR_W-1:0]      RdW,
  input  logic                   RegWriteM,
  input  logic                   RegWriteW,
  input  logic                   MemReadE,
  input  logic                   MultiCycleE,
  input  logic                   PCSrcE,
  output logic [2*NSRC-1:0]      ForwardE,
  output logic                   StallF,
  output logic                   StallD,
  output logic                   StallE,
  output logic                   FlushD,
  output logic                   FlushE,
  output logic                   FlushM,
  output logic                   Busy
);

  localparam int CNT_W = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              mc_stall;
  logic              lu;
  logic [ADDR_W-1:0] src;

  // Per-source forwarding; the M stage result is newer, so it wins over W.
  always_comb begin
    ForwardE = '0;
    src      = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      src = RsE[i*ADDR_W +: ADDR_W];
      if (RegWriteM && (src == RdM) && (src != '0))
        ForwardE[2*i +: 2] = 2'b10;
      else if (RegWriteW && (src == RdW) && (src != '0))
        ForwardE[2*i +: 2] = 2'b01;
    end
  end

  always_comb begin
    lu = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (RsD[i*ADDR_W +: ADDR_W] == RdE)
        lu = 1'b1;
    end
    lu = lu & MemReadE & (RdE != '0);
  end

  // The trigger cycle stalls from IDLE; the release cycle (cnt == 0) does not.
  assign mc_stall = ((state == IDLE) && MultiCycleE && !reset) ||
                    ((state == BUSY) && (cnt != '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MultiCycleE) begin
            state <= BUSY;
            cnt   <= CNT_W'(MD_LAT - 2);
          end
        end
        BUSY: begin
          if (cnt != '0)
            cnt <= cnt - 1'b1;
          else
            state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign StallF = mc_stall | (lu & ~PCSrcE & ~mc_stall);
  assign StallD = StallF;
  assign StallE = mc_stall;
  assign FlushM = mc_stall;
  assign FlushE = ~mc_stall & (PCSrcE | lu);
  assign FlushD = ~mc_stall & PCSrcE;
  assign Busy   = (state == BUSY);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (MD_LAT=4 and MD_LAT=2, NSRC=3)
// share stimulus; expectations come from an op-age reference model.
module tb_hazard_ctrl;

  localparam int AW = 5;
  localparam int NS = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [NS*AW-1:0] RsD, RsE;
  logic [AW-1:0]   RdE, RdM, RdW;
  logic            RegWriteM, RegWriteW, MemReadE, MultiCycleE, PCSrcE;

  logic [2*NS-1:0] fe_a, fe_b;
  logic sf_a, sd_a, se_a, fd_a, fe1_a, fm_a, bz_a;
  logic sf_b, sd_b, se_b, fd_b, fe1_b, fm_b, bz_b;

  always #5 clk = ~clk;

  hazard_ctrl #(.ADDR_W(AW), .NSRC(NS), .MD_LAT(4)) dut_a (
    .clk(clk), .reset(reset), .RsD(RsD), .RsE(RsE), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemReadE(MemReadE),
    .MultiCycleE(MultiCycleE), .PCSrcE(PCSrcE), .ForwardE(fe_a),
    .StallF(sf_a), .StallD(sd_a), .StallE(se_a), .FlushD(fd_a), .FlushE(fe1_a),
    .FlushM(fm_a), .Busy(bz_a));

  hazard_ctrl #(.ADDR_W(AW), .NSRC(NS), .MD_LAT(2)) dut_b (
    .clk(clk), .reset(reset), .RsD(RsD), .RsE(RsE), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemReadE(MemReadE),
    .MultiCycleE(MultiCycleE), .PCSrcE(PCSrcE), .ForwardE(fe_b),
    .StallF(sf_b), .StallD(sd_b), .StallE(se_b), .FlushD(fd_b), .FlushE(fe1_b),
    .FlushM(fm_b), .Busy(bz_b));

  // Vector layout: {ForwardE[5:0], StallF, StallD, StallE, FlushD, FlushE, FlushM, Busy}
  typedef struct {
    int          cyc;
    logic [12:0] a;
    logic [12:0] b;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   age_a = -1;  // cycles the multi-cycle op has spent in EX; -1 = none
  int   age_b = -1;

  function automatic logic [5:0] ref_fwd();
    logic [5:0]    f;
    logic [AW-1:0] s;
    f = '0;
    for (int i = 0; i < NS; i++) begin
      s = RsE[i*AW +: AW];
      if (s != 0 && RegWriteM && s == RdM)      f[2*i +: 2] = 2'b10;
      else if (s != 0 && RegWriteW && s == RdW) f[2*i +: 2] = 2'b01;
    end
    return f;
  endfunction

  function automatic logic ref_lu();
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NS; i++)
      if (RsD[i*AW +: AW] == RdE) hit = 1'b1;
    return MemReadE && RdE != 0 && hit;
  endfunction

  function automatic int cur_age(input int age);
    if (age < 0 && MultiCycleE && !reset) return 0;
    return age;
  endfunction

  function automatic int next_age(input int cur, input int lat);
    if (reset || cur < 0 || cur == lat - 1) return -1;
    return cur + 1;
  endfunction

  function automatic logic [12:0] ref_out(input int cur, input int lat);
    logic mc, lu, sf;
    mc = (cur >= 0) && (cur < lat - 1);
    lu = ref_lu();
    sf = mc || (lu && !PCSrcE);
    return {ref_fwd(), sf, sf, mc, !mc && PCSrcE, !mc && (PCSrcE || lu), mc, cur >= 1};
  endfunction

  task automatic step();
    exp_t e;
    int ca, cb;
    ca = cur_age(age_a);
    cb = cur_age(age_b);
    e.cyc = cyc;
    e.a   = ref_out(ca, 4);
    e.b   = ref_out(cb, 2);
    q.push_back(e);
    age_a = next_age(ca, 4);
    age_b = next_age(cb, 2);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_inputs();
    reset = 1'b0; RsD = '0; RsE = '0; RdE = '0; RdM = '0; RdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; MemReadE = 1'b0;
    MultiCycleE = 1'b0; PCSrcE = 1'b0;
  endtask

  // Monitor: outputs are valid every cycle, so one entry is consumed per negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({fe_a, sf_a, sd_a, se_a, fd_a, fe1_a, fm_a, bz_a} !== e.a) begin
          errors++;
          $display("FAIL lat4 cycle=%0d got=%b expected=%b", e.cyc,
                   {fe_a, sf_a, sd_a, se_a, fd_a, fe1_a, fm_a, bz_a}, e.a);
        end
        checks++;
        if ({fe_b, sf_b, sd_b, se_b, fd_b, fe1_b, fm_b, bz_b} !== e.b) begin
          errors++;
          $display("FAIL lat2 cycle=%0d got=%b expected=%b", e.cyc,
                   {fe_b, sf_b, sd_b, se_b, fd_b, fe1_b, fm_b, bz_b}, e.b);
        end
      end
    end
  end

  initial begin
    clear_inputs();
    reset = 1'b1;
    MultiCycleE = 1'b1;
    @(posedge clk);
    #1;
    step();  // reset cycle with a pending trigger: suppressed
    clear_inputs();
    step();

    // Forwarding: sources {x0, x5, x3}, M writes x5, W writes x3
    RsE = {5'd0, 5'd5, 5'd3}; RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd3; RegWriteW = 1'b1;
    step();
    RsE = {5'd0, 5'd0, 5'd7}; RdM = 5'd7; RdW = 5'd7;
    step();
    RegWriteM = 1'b0;
    step();
    RsE = '0; RdM = '0; RdW = '0; RegWriteM = 1'b1;
    step();
    clear_inputs();

    // Load-use on source 1, then with RdE = x0
    MemReadE = 1'b1; RdE = 5'd4; RsD = {5'd0, 5'd4, 5'd9};
    step();
    MemReadE = 1'b0; RsE = {5'd0, 5'd4, 5'd9}; RdW = 5'd4; RegWriteW = 1'b1;
    step();
    clear_inputs();
    MemReadE = 1'b1; RdE = 5'd0; RsD = {5'd0, 5'd0, 5'd0};
    step();
    clear_inputs();

    // Branch and load-use together
    MemReadE = 1'b1; RdE = 5'd6; RsD = {5'd6, 5'd1, 5'd2}; PCSrcE = 1'b1;
    step();
    clear_inputs();

    // Multi-cycle held high across release and retrigger
    MultiCycleE = 1'b1;
    repeat (6) step();
    MultiCycleE = 1'b0;
    repeat (3) step();

    // Branch and load while busy
    MultiCycleE = 1'b1;
    step();
    MultiCycleE = 1'b0; PCSrcE = 1'b1; MemReadE = 1'b1; RdE = 5'd2; RsD = {5'd2, 5'd0, 5'd0};
    repeat (3) step();
    clear_inputs();
    step();

    // Reset in the second BUSY cycle
    MultiCycleE = 1'b1;
    step();
    step();
    reset = 1'b1;
    step();
    clear_inputs();
    repeat (3) step();

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      reset       = ($urandom_range(0, 49) == 0);
      RsD         = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      RsE         = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      RdE         = 5'($urandom_range(0, 7));
      RdM         = 5'($urandom_range(0, 7));
      RdW         = 5'($urandom_range(0, 7));
      RegWriteM   = 1'($urandom_range(0, 1));
      RegWriteW   = 1'($urandom_range(0, 1));
      MemReadE    = ($urandom_range(0, 9) < 3);
      MultiCycleE = ($urandom_range(0, 9) < 2);
      PCSrcE      = ($urandom_range(0, 9) < 2);
      step();
    end
    clear_inputs();
    @(posedge clk);
    #1;

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
